// File: rtl/traffic_conflict_monitor.sv
// Safety supervisor between the traffic light controller and the lamp drivers.
// It passes legal NS/EW one-hot light codes through with one cycle of latency.
// On a conflict, an illegal code, an illegal sequence or a short yellow it
// latches the first cause and flashes red on both directions. An operator
// clear, taken only while both inputs are red, starts a timed all-red
// recovery before passthrough resumes.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   ns_light_in  controller NS code (001 green, 010 yellow, 100 red)
//   ew_light_in  controller EW code, same encoding
//   fault_clr    operator fault clear, level-sampled each cycle
//   ns_lamp      registered NS lamp drive
//   ew_lamp      registered EW lamp drive
//   fault        high from fault entry until recovery completes
//   fault_code   first-fault cause (1 encoding, 2 conflict, 3 sequence, 4 short yellow)
module traffic_conflict_monitor #(
  parameter int unsigned        TIMER_W    = 16,
  parameter logic [TIMER_W-1:0] MIN_YELLOW = 16'd10000,
  parameter logic [TIMER_W-1:0] FLASH_HALF = 16'd25000,
  parameter logic [TIMER_W-1:0] ALL_RED    = 16'd5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ns_light_in,
  input  logic [2:0] ew_light_in,
  input  logic       fault_clr,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] DARK = 3'b000;
  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         ns_lamp_q, ns_lamp_d;
  logic [2:0]         ew_lamp_q, ew_lamp_d;
  logic               fault_q, fault_d;
  logic [2:0]         fault_code_q, fault_code_d;
  logic [2:0]         ns_prev_q, ew_prev_q;
  logic [TIMER_W-1:0] ns_ycnt_q, ns_ycnt_d;
  logic [TIMER_W-1:0] ew_ycnt_q, ew_ycnt_d;
  logic [TIMER_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_on_q, flash_on_d;
  logic [TIMER_W-1:0] rec_cnt_q, rec_cnt_d;
  logic [2:0]         chk_code;

  function automatic logic legal_code(input logic [2:0] c);
    return (c == GRN) || (c == YEL) || (c == RED);
  endfunction

  function automatic logic bad_trans(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == GRN) && (cur == RED)) ||
           ((prev == RED) && (cur == YEL)) ||
           ((prev == YEL) && (cur == GRN));
  endfunction

  // Consecutive-yellow length: 1 on entry, saturating count while held.
  function automatic logic [TIMER_W-1:0] ycnt_next(input logic [TIMER_W-1:0] cnt,
                                                   input logic [2:0] prev,
                                                   input logic [2:0] cur);
    logic [TIMER_W-1:0] n;
    n = cnt;
    if (cur == YEL) begin
      if (prev != YEL)        n = ONE;
      else if (cnt != '1)     n = cnt + ONE;
    end
    return n;
  endfunction

  function automatic logic short_yel(input logic [TIMER_W-1:0] cnt,
                                     input logic [2:0] prev,
                                     input logic [2:0] cur);
    return (prev == YEL) && (cur == RED) && (cnt < MIN_YELLOW);
  endfunction

  // Safety checks, lowest code has priority.
  always_comb begin
    chk_code = 3'd0;
    if (!legal_code(ns_light_in) || !legal_code(ew_light_in)) begin
      chk_code = 3'd1;
    end else if ((ns_light_in != RED) && (ew_light_in != RED)) begin
      chk_code = 3'd2;
    end else if (bad_trans(ns_prev_q, ns_light_in) || bad_trans(ew_prev_q, ew_light_in)) begin
      chk_code = 3'd3;
    end else if (short_yel(ns_ycnt_q, ns_prev_q, ns_light_in) ||
                 short_yel(ew_ycnt_q, ew_prev_q, ew_light_in)) begin
      chk_code = 3'd4;
    end
  end

  always_comb begin
    ns_ycnt_d = ycnt_next(ns_ycnt_q, ns_prev_q, ns_light_in);
    ew_ycnt_d = ycnt_next(ew_ycnt_q, ew_prev_q, ew_light_in);
  end

  // Supervisor next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ns_lamp_d    = ns_lamp_q;
    ew_lamp_d    = ew_lamp_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    flash_cnt_d  = flash_cnt_q;
    flash_on_d   = flash_on_q;
    rec_cnt_d    = rec_cnt_q;

    unique case (state_q)
      ST_NORMAL: begin
        if (chk_code != 3'd0) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = chk_code;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b1;
          ns_lamp_d    = RED;
          ew_lamp_d    = RED;
        end else begin
          ns_lamp_d = ns_light_in;
          ew_lamp_d = ew_light_in;
        end
      end

      ST_FAULT: begin
        if (flash_cnt_q == FLASH_HALF - ONE) begin
          flash_cnt_d = '0;
          flash_on_d  = ~flash_on_q;
        end else begin
          flash_cnt_d = flash_cnt_q + ONE;
        end
        ns_lamp_d = flash_on_d ? RED : DARK;
        ew_lamp_d = flash_on_d ? RED : DARK;
        if (fault_clr && (ns_light_in == RED) && (ew_light_in == RED)) begin
          state_d   = ST_RECOVER;
          ns_lamp_d = RED;
          ew_lamp_d = RED;
          rec_cnt_d = '0;
        end
      end

      ST_RECOVER: begin
        ns_lamp_d = RED;
        ew_lamp_d = RED;
        rec_cnt_d = rec_cnt_q + ONE;
        if (chk_code != 3'd0) begin
          state_d      = ST_FAULT;
          fault_code_d = chk_code;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b1;
        end else if (rec_cnt_q == ALL_RED - ONE) begin
          state_d      = ST_NORMAL;
          fault_d      = 1'b0;
          fault_code_d = 3'd0;
        end
      end

      default: begin
        state_d   = ST_NORMAL;
        ns_lamp_d = RED;
        ew_lamp_d = RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      ns_lamp_q    <= RED;
      ew_lamp_q    <= RED;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
      ns_prev_q    <= RED;
      ew_prev_q    <= RED;
      ns_ycnt_q    <= '0;
      ew_ycnt_q    <= '0;
      flash_cnt_q  <= '0;
      flash_on_q   <= 1'b0;
      rec_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ns_lamp_q    <= ns_lamp_d;
      ew_lamp_q    <= ew_lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      ns_prev_q    <= ns_light_in;
      ew_prev_q    <= ew_light_in;
      ns_ycnt_q    <= ns_ycnt_d;
      ew_ycnt_q    <= ew_ycnt_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_on_q   <= flash_on_d;
      rec_cnt_q    <= rec_cnt_d;
    end
  end

  assign ns_lamp    = ns_lamp_q;
  assign ew_lamp    = ew_lamp_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed vector table, asynchronous
// reset in FAULT, then randomized stimulus against a behavioural model.
module tb_traffic_conflict_monitor;

  localparam int MIN_Y = 4;
  localparam int FLASH = 3;
  localparam int ALLR  = 5;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ns_light_in, ew_light_in;
  logic       fault_clr;
  logic [2:0] ns_lamp, ew_lamp;
  logic       fault;
  logic [2:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_conflict_monitor #(
    .TIMER_W   (16),
    .MIN_YELLOW(16'd4),
    .FLASH_HALF(16'd3),
    .ALL_RED   (16'd5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ns_light_in(ns_light_in),
    .ew_light_in(ew_light_in),
    .fault_clr  (fault_clr),
    .ns_lamp    (ns_lamp),
    .ew_lamp    (ew_lamp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       clr;
    int         rep;
    logic [2:0] ens;
    logic [2:0] eew;
    logic       ef;
    logic [2:0] ecode;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [2:0] ns, logic [2:0] ew, logic clr, int rep,
                              logic [2:0] ens, logic [2:0] eew, logic ef, logic [2:0] ecode);
    vec_t v;
    v.ns = ns; v.ew = ew; v.clr = clr; v.rep = rep;
    v.ens = ens; v.eew = eew; v.ef = ef; v.ecode = ecode;
    tbl.push_back(v);
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 passthrough, 1 flashing fault, 2 all-red recovery
  int         m_mode, m_since, m_yns, m_yew;
  logic [2:0] m_pns, m_pew, m_lns, m_lew, m_code;
  logic       m_fault;

  function automatic int idx(logic [2:0] c);
    if (c == G) return 0;
    if (c == Y) return 1;
    if (c == R) return 2;
    return -1;
  endfunction

  // A light may hold or advance one step around green->yellow->red->green.
  function automatic bit step_ok(logic [2:0] p, logic [2:0] c);
    return (c == p) || (idx(c) == (idx(p) + 1) % 3);
  endfunction

  function automatic int m_check(logic [2:0] ns, logic [2:0] ew);
    if (idx(ns) < 0 || idx(ew) < 0) return 1;
    if (ns != R && ew != R) return 2;
    if (!step_ok(m_pns, ns) || !step_ok(m_pew, ew)) return 3;
    if ((m_pns == Y && ns == R && m_yns < MIN_Y) ||
        (m_pew == Y && ew == R && m_yew < MIN_Y)) return 4;
    return 0;
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_since = 0; m_yns = 0; m_yew = 0;
    m_pns = R; m_pew = R; m_lns = R; m_lew = R; m_code = 3'd0; m_fault = 1'b0;
  endfunction

  function automatic void m_enter_fault(int code);
    m_mode = 1; m_since = 0; m_fault = 1'b1; m_code = 3'(code);
    m_lns = R; m_lew = R;
  endfunction

  function automatic void m_step(logic [2:0] ns, logic [2:0] ew, logic clr);
    int code;
    code = m_check(ns, ew);
    case (m_mode)
      0: begin
        if (code != 0) m_enter_fault(code);
        else begin m_lns = ns; m_lew = ew; end
      end
      1: begin
        m_since++;
        m_lns = ((m_since / FLASH) % 2 == 0) ? R : D;
        m_lew = m_lns;
        if (clr && ns == R && ew == R) begin
          m_mode = 2; m_since = 0; m_lns = R; m_lew = R;
        end
      end
      default: begin
        if (code != 0) m_enter_fault(code);
        else begin
          m_since++;
          m_lns = R; m_lew = R;
          if (m_since == ALLR) begin m_mode = 0; m_fault = 1'b0; m_code = 3'd0; end
        end
      end
    endcase
    if (ns == Y) m_yns = (m_pns == Y) ? m_yns + 1 : 1;
    if (ew == Y) m_yew = (m_pew == Y) ? m_yew + 1 : 1;
    m_pns = ns;
    m_pew = ew;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ns=%b ew=%b fault=%b code=%0d, expected ns=%b ew=%b fault=%b code=%0d",
               name, act[9:7], act[6:4], act[3], act[2:0], exp[9:7], exp[6:4], exp[3], exp[2:0]);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {ns_lamp, ew_lamp, fault, fault_code};
  endfunction

  task automatic apply(logic [2:0] ns, logic [2:0] ew, logic clr);
    ns_light_in = ns;
    ew_light_in = ew;
    fault_clr   = clr;
    @(posedge clk);
    #1;
    m_step(ns, ew, clr);
  endtask

  function automatic logic [2:0] rnd_next(logic [2:0] cur);
    int r;
    logic [2:0] v;
    r = $urandom_range(0, 99);
    if (r < 50) return cur;
    if (r < 85) begin
      case (cur)
        G: return Y;
        Y: return R;
        default: return G;
      endcase
    end
    if (r < 95) begin
      v = 3'b001 << $urandom_range(0, 2);
      return v;
    end
    v = 3'($urandom_range(0, 7));
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [2:0] rns, rew;
    logic       rclr;

    rst = 1'b1; ns_light_in = R; ew_light_in = R; fault_clr = 1'b0;
    m_reset();
    #3;
    chk("reset_values", dut_vec(), {R, R, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;

    // legal full cycle
    add(G, R, 0, 10, G, R, 0, 0);
    add(Y, R, 0, 4,  Y, R, 0, 0);
    add(R, R, 0, 1,  R, R, 0, 0);
    add(R, G, 0, 3,  R, G, 0, 0);
    add(R, Y, 0, 4,  R, Y, 0, 0);
    add(R, R, 0, 1,  R, R, 0, 0);
    add(G, R, 0, 2,  G, R, 0, 0);
    // conflict and flashing, clear ignored while NS is green
    add(G, G, 0, 1,  R, R, 1, 2);
    add(G, G, 0, 2,  R, R, 1, 2);
    add(G, G, 0, 3,  D, D, 1, 2);
    add(G, R, 1, 2,  R, R, 1, 2);
    // clear handshake and all-red recovery
    add(R, R, 1, 1,  R, R, 1, 2);
    add(R, R, 0, 4,  R, R, 1, 2);
    add(R, R, 0, 1,  R, R, 0, 0);
    add(G, R, 0, 1,  G, R, 0, 0);
    // green->red alone is an illegal transition
    add(R, R, 0, 1,  R, R, 1, 3);
    add(R, R, 1, 1,  R, R, 1, 3);
    // EW going green during recovery is legal
    add(R, G, 0, 4,  R, R, 1, 3);
    add(R, G, 0, 1,  R, R, 0, 0);
    add(R, G, 0, 1,  R, G, 0, 0);
    // illegal code during recovery re-enters FAULT with flash restarted
    add(G, G, 0, 1,  R, R, 1, 2);
    add(R, R, 1, 1,  R, R, 1, 2);
    add(R, 3'b011, 0, 1, R, R, 1, 1);
    add(R, 3'b011, 0, 2, R, R, 1, 1);
    add(R, 3'b011, 0, 3, D, D, 1, 1);
    add(R, R, 1, 1,  R, R, 1, 1);
    add(R, R, 0, 4,  R, R, 1, 1);
    add(R, R, 0, 1,  R, R, 0, 0);
    // short yellow
    add(G, R, 0, 1,  G, R, 0, 0);
    add(Y, R, 0, 2,  Y, R, 0, 0);
    add(R, R, 0, 1,  R, R, 1, 4);
    add(R, R, 1, 1,  R, R, 1, 4);
    add(R, R, 0, 4,  R, R, 1, 4);
    add(R, R, 0, 1,  R, R, 0, 0);
    // illegal transition plus illegal encoding: encoding wins
    add(G, R, 0, 1,  G, R, 0, 0);
    add(R, 3'b011, 0, 1, R, R, 1, 1);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        apply(tbl[i].ns, tbl[i].ew, tbl[i].clr);
        chk($sformatf("vec%0d_cyc%0d", i, k), dut_vec(),
            {tbl[i].ens, tbl[i].eew, tbl[i].ef, tbl[i].ecode});
      end
    end

    // asynchronous reset between edges while in FAULT
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_mid_fault", dut_vec(), {R, R, 1'b0, 3'd0});
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(G, R, 1'b0);
    chk("post_reset_passthrough", dut_vec(), {G, R, 1'b0, 3'd0});

    // randomized run against the model
    rns = G; rew = R;
    for (int c = 0; c < 600; c++) begin
      rns  = rnd_next(rns);
      rew  = rnd_next(rew);
      rclr = ($urandom_range(0, 2) == 0);
      if (m_mode == 1 && $urandom_range(0, 1) == 0) begin
        rns = R; rew = R;
      end
      apply(rns, rew, rclr);
      chk($sformatf("rand_cyc%0d", c), dut_vec(), {m_lns, m_lew, m_fault, m_code});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
